sync_capture_ctrl: RTL and testbench

SYNC_CAPTURE_CTRL -- requirements
Module: sync_capture_ctrl

---
 rtl/sync_ctrl_pkg.sv | 19 +
 rtl/sync_stage.sv | 28 ++
 rtl/sync_capture_ctrl.sv | 150 +++++++++++++++
 tb/tb_sync_capture_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ctrl_pkg.sv
// Shared definitions for the toggle-handshake capture controller.
// Holds the FSM state encoding, the data/counter widths and the default
// stability/timeout parameter values used by sync_capture_ctrl.
package sync_ctrl_pkg;

  localparam int DATA_W             = 10;
  localparam int STAB_CNT_W         = 4;
  localparam int TMO_CNT_W          = 8;
  localparam int STABLE_CYCLES_DEF  = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_STABLE = 2'd1,
    ST_VALID       = 2'd2,
    ST_ACK         = 2'd3
  } state_t;

endpackage

// File: rtl/sync_stage.sv
// Two-flop synchronizer for a WIDTH-bit bus; no handshake of its own.
// Latency: 2 clk cycles. Backpressure: none, samples every cycle.
// Ports: clk, rst_n (async active-low), i_d (raw input), o_q (synchronized).
module sync_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sync_capture_ctrl.sv
// Captures a word from an off-chip sender using a toggle req/ack handshake,
// accepting it only after the synchronized data has been stable for
// STABLE_CYCLES consecutive samples. Latency: STABLE_CYCLES+3 cycles from a
// req toggle to data_valid. Backpressure: data_valid/data_out hold until
// out_ready; ack is withheld until the word is taken or the wait times out.
// Ports: clk, rst_n (async active-low); async_data/async_req from the sender;
// ack toggle back to the sender; data_out/data_valid/out_ready downstream;
// err_timeout sticky abort flag with err_clr synchronous clear.
module sync_capture_ctrl
  import sync_ctrl_pkg::*;
#(
  parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] async_data,
  input  logic              async_req,
  output logic              ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              out_ready,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam logic [STAB_CNT_W-1:0] STAB_LAST = STAB_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_CNT_W-1:0]  TMO_LAST  = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [DATA_W-1:0]     w_data_s;
  logic                  w_req_s;
  logic                  w_req_edge;
  logic                  w_match;
  logic                  w_capture;
  logic                  w_tmo_hit;

  state_t                r_state,      w_state_nxt;
  logic                  r_req_d;
  logic [DATA_W-1:0]     r_data_prev,  w_data_prev_nxt;
  logic [STAB_CNT_W-1:0] r_stab_cnt,   w_stab_cnt_nxt;
  logic [TMO_CNT_W-1:0]  r_tmo_cnt,    w_tmo_cnt_nxt;
  logic                  r_ack,        w_ack_nxt;
  logic [DATA_W-1:0]     r_data_out,   w_data_out_nxt;
  logic                  r_data_valid, w_data_valid_nxt;
  logic                  r_err,        w_err_nxt;

  sync_stage #(.WIDTH(DATA_W)) u_sync_data (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (async_data),
    .o_q   (w_data_s)
  );

  sync_stage #(.WIDTH(1)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (async_req),
    .o_q   (w_req_s)
  );

  // Any level change of the synchronized request marks a new word.
  assign w_req_edge = w_req_s ^ r_req_d;
  assign w_match    = (w_data_s == r_data_prev);
  assign w_capture  = (r_state == ST_WAIT_STABLE) && w_match && (r_stab_cnt == STAB_LAST);
  // Capture takes priority when stability and timeout land on the same cycle.
  assign w_tmo_hit  = (r_state == ST_WAIT_STABLE) && (r_tmo_cnt == TMO_LAST) && !w_capture;

  always_comb begin
    w_state_nxt      = r_state;
    w_data_prev_nxt  = r_data_prev;
    w_stab_cnt_nxt   = r_stab_cnt;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_ack_nxt        = r_ack;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = r_data_valid;
    w_err_nxt        = r_err;

    case (r_state)
      ST_IDLE: begin
        if (w_req_edge) begin
          w_state_nxt     = ST_WAIT_STABLE;
          w_stab_cnt_nxt  = '0;
          w_tmo_cnt_nxt   = '0;
          w_data_prev_nxt = w_data_s;
        end
      end
      ST_WAIT_STABLE: begin
        w_data_prev_nxt = w_data_s;
        w_tmo_cnt_nxt   = r_tmo_cnt + 1'b1;
        w_stab_cnt_nxt  = w_match ? (r_stab_cnt + 1'b1) : '0;
        if (w_capture) begin
          w_data_out_nxt   = w_data_s;
          w_data_valid_nxt = 1'b1;
          w_state_nxt      = ST_VALID;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_VALID: begin
        if (out_ready) begin
          w_data_valid_nxt = 1'b0;
          w_state_nxt      = ST_ACK;
        end
      end
      ST_ACK: begin
        // Echo the request level the word was launched with.
        w_ack_nxt   = r_req_d;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Set dominates clear so a coincident clear cannot hide an abort.
    if (w_tmo_hit) begin
      w_err_nxt = 1'b1;
    end else if (err_clr) begin
      w_err_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_req_d      <= 1'b0;
      r_data_prev  <= '0;
      r_stab_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_ack        <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_d      <= w_req_s;
      r_data_prev  <= w_data_prev_nxt;
      r_stab_cnt   <= w_stab_cnt_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_ack        <= w_ack_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign ack         = r_ack;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_sync_capture_ctrl.sv
module tb_sync_capture_ctrl;

  localparam int STABLE = 4;
  localparam int TMO    = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] async_data;
  logic       async_req;
  logic       ack;
  logic [9:0] data_out;
  logic       data_valid;
  logic       out_ready;
  logic       err_timeout;
  logic       err_clr;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic req_lvl  = 1'b0;
  // hist[k] is the async_data value sampled by the DUT at clock edge k.
  logic [9:0] hist [0:8191];

  sync_capture_ctrl #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_data  (async_data),
    .async_req   (async_req),
    .ack         (ack),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .out_ready   (out_ready),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; record the sampled data; return 1 time unit later.
  task automatic tick();
    @(posedge clk);
    cyc = cyc + 1;
    hist[13'(cyc)] = async_data;
    #1;
  endtask

  // Reference: a word launched at edge t0 is captured at the first edge e
  // where the STABLE+1 synchronized samples hist[e-2-STABLE .. e-2] are all
  // equal and none predates t0; if none exists by edge t0+2+TMO, it aborts.
  function automatic int predict(input int t0);
    for (int e = t0 + 3; e <= t0 + 2 + TMO; e++) begin
      bit ok;
      ok = 1'b1;
      if (e - 2 - STABLE < t0) continue;
      for (int j = 1; j <= STABLE; j++)
        if (hist[13'(e - 2 - j)] !== hist[13'(e - 2)]) ok = 1'b0;
      if (ok) return e;
    end
    return -1;
  endfunction

  // mode 0: stable val; 1: random noise then val; 2: val/~val every 2 cycles.
  task automatic monitor(input int t0, input int mode, input logic [9:0] val,
                         input int rdy, input bit clr_pulse,
                         output int e_obs, output logic [9:0] d_obs, output int err_rise);
    int   f_obs, ack_edge, dv_cnt, noise_n, pred, acc;
    logic ack0, err0;
    f_obs = -1; ack_edge = -1; dv_cnt = 0;
    e_obs = -1; err_rise = -1; d_obs = '0;
    noise_n = $urandom_range(0, 20);
    ack0 = ack; err0 = err_timeout;
    out_ready = (rdy == 0);
    for (int n = 0; n < 400 && ack_edge < 0; n++) begin
      int j;
      j = cyc + 1 - t0;
      if (e_obs >= 0) async_data = 10'($urandom);
      else case (mode)
        1:       async_data = (j < noise_n) ? 10'($urandom) : val;
        2:       async_data = (((j / 2) % 2) == 0) ? val : ~val;
        default: async_data = val;
      endcase
      err_clr = clr_pulse && (cyc + 1 == t0 + 2 + TMO);
      tick();
      if (data_valid) begin
        if (e_obs < 0) begin
          e_obs = cyc;
          d_obs = data_out;
        end else begin
          chk("hold_data", 32'(data_out), 32'(d_obs));
        end
        chk("hold_ack", 32'(ack), 32'(ack0));
        dv_cnt++;
        if (dv_cnt >= rdy) out_ready = 1'b1;
      end else if (e_obs >= 0 && f_obs < 0) begin
        f_obs = cyc;
        out_ready = 1'b0;
      end
      if (err_timeout && !err0 && err_rise < 0) err_rise = cyc;
      if (ack !== ack0) ack_edge = cyc;
    end
    err_clr = 1'b0;
    out_ready = 1'b0;
    chk("txn_budget", 32'(ack_edge >= 0), 32'd1);
    pred = predict(t0);
    if (pred >= 0) begin
      acc = pred + ((rdy > 1) ? rdy : 1);
      chk("cap_edge", e_obs, pred);
      chk("cap_data", 32'(d_obs), 32'(hist[13'(pred - 2)]));
      chk("accept_edge", f_obs, acc);
      chk("ack_edge", ack_edge, acc + 1);
      chk("no_err", err_rise, -1);
    end else begin
      chk("no_valid", e_obs, -1);
      chk("err_edge", err_rise, t0 + 2 + TMO);
      chk("ack_edge_tmo", ack_edge, t0 + 3 + TMO);
    end
    chk("ack_level", 32'(ack), 32'(req_lvl));
  endtask

  task automatic send(input int mode, input logic [9:0] val, input int rdy, input bit clr_pulse,
                      output int t0, output int e_obs, output logic [9:0] d_obs, output int err_rise);
    repeat ($urandom_range(0, 2)) tick();
    req_lvl = ~req_lvl;
    async_req = req_lvl;
    t0 = cyc + 1;
    monitor(t0, mode, val, rdy, clr_pulse, e_obs, d_obs, err_rise);
  endtask

  initial begin
    int         t0, e, er;
    logic [9:0] d;
    logic [9:0] words [3];
    bit         seen;
    words[0] = 10'h001; words[1] = 10'h3FF; words[2] = 10'h2AA;

    rst_n = 1'b0; async_req = 1'b0; async_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Basic capture of a held word with out_ready already high.
    async_data = 10'h155;
    tick(); tick();
    send(0, 10'h155, 0, 1'b0, t0, e, d, er);
    chk("latency7", e - (t0 - 1), 7);
    chk("word_155", 32'(d), 32'h155);
    chk("ack_high", 32'(ack), 32'd1);

    // Three back-to-back words.
    for (int i = 0; i < 3; i++) begin
      send(0, words[i], $urandom_range(0, 3), 1'b0, t0, e, d, er);
      chk("b2b_word", 32'(d), 32'(words[i]));
    end

    // Long backpressure while the sender's data wanders.
    send(0, 10'($urandom), 20, 1'b0, t0, e, d, er);

    // Randomized words, noise and ready delays.
    repeat (8) send($urandom_range(0, 1), 10'($urandom), $urandom_range(0, 4), 1'b0, t0, e, d, er);

    // Timeout on data toggling every 2 cycles.
    send(2, 10'($urandom), 0, 1'b0, t0, e, d, er);
    chk("tmo_set", 32'(err_timeout), 32'd1);
    chk("tmo_255", er - (t0 + 2), 255);
    repeat (5) tick();
    chk("tmo_sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_cleared", 32'(err_timeout), 32'd0);

    // Clear pulsed on the very cycle the timeout fires.
    send(2, 10'($urandom), 0, 1'b1, t0, e, d, er);
    chk("set_beats_clr", 32'(err_timeout), 32'd1);
    tick();
    chk("set_beats_clr_hold", 32'(err_timeout), 32'd1);

    // Reset in the middle of WAIT_STABLE.
    req_lvl = ~req_lvl;
    async_req = req_lvl;
    for (int n = 0; n < 10; n++) begin
      async_data = (n % 2 == 0) ? 10'h0F0 : 10'h30F;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_err", 32'(err_timeout), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (data_valid) seen = 1'b1;
    end
    req_lvl = 1'b1;
    async_req = 1'b1;
    rst_n = 1'b1;
    t0 = cyc + 1;
    monitor(t0, 0, 10'h2C3, 1, 1'b0, e, d, er);
    chk("post_rst_word", 32'(d), 32'h2C3);
    repeat (12) begin
      tick();
      if (data_valid) seen = 1'b1;
    end
    chk("no_extra_valid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
